// File: rtl/sr_bank_driver_pkg.sv
// Shared definitions for the SR bank driver: FSM state encodings,
// default pulse/settle timing and a small elaboration-time helper.
package sr_bank_driver_pkg;

    localparam int DEF_PULSE_CYCLES  = 2;
    localparam int DEF_SETTLE_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_PULSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4
    } sr_state_t;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// Request channel of the SR bank driver.
// Handshake: a request transfers at a posedge where req_valid and
// req_ready are both high; the requester holds req_valid/data/mask
// stable until that edge, and the driver ignores them while not ready.
interface sr_bank_driver_if #(
    parameter int N = 8
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_data;
    logic [N-1:0] req_mask;

    modport master (output req_valid, req_data, req_mask, input req_ready);
    modport slave  (input req_valid, req_data, req_mask, output req_ready);
endinterface

// File: rtl/sr_cmd_encode.sv
// Turns a masked target update into set/reset vectors for an SR bank.
// Only bits that are masked in and differ from the shadow get a pulse,
// and a bit can never be both set and reset.
module sr_cmd_encode #(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    input  logic [N-1:0] mask,
    input  logic [N-1:0] shadow,
    output logic [N-1:0] set_v,
    output logic [N-1:0] rst_v
);

    assign set_v = mask &  data & ~shadow;
    assign rst_v = mask & ~data &  shadow;

endmodule

// File: rtl/sr_bank_driver.sv
// Command-side driver for a bank of SR flip-flops. Accepts masked
// target updates, converts them into timed set/reset pulses, checks
// the bank's q feedback afterwards and keeps a shadow of the bank.
module sr_bank_driver
    import sr_bank_driver_pkg::*;
#(
    parameter int N             = 8,
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    sr_bank_driver_if.slave    req,
    output logic [N-1:0]       s,
    output logic [N-1:0]       r,
    input  logic [N-1:0]       q_fb,
    output logic [N-1:0]       q_shadow,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [N-1:0]       err_bits,
    input  logic               err_clr,
    output sr_state_t          state_dbg
);

    localparam int CW = $clog2(max_int(PULSE_CYCLES, SETTLE_CYCLES) + 1);

    sr_state_t    state;
    logic [CW-1:0] cnt;
    logic [N-1:0] lat_data;
    logic [N-1:0] lat_mask;
    logic [N-1:0] set_v;
    logic [N-1:0] rst_v;
    logic [N-1:0] mism;
    logic         accept;

    sr_cmd_encode #(.N(N)) u_encode (
        .data   (req.req_data),
        .mask   (req.req_mask),
        .shadow (q_shadow),
        .set_v  (set_v),
        .rst_v  (rst_v)
    );

    assign accept    = req.req_valid & req.req_ready;
    assign state_dbg = state;

    // Feedback mismatch exists only during CHECK, against the latched target.
    assign mism = (state == ST_CHECK) ? (lat_mask & (q_fb ^ lat_data)) : '0;

    // Sequencer: phase counter, pulse outputs, handshake and shadow update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_INIT;
            cnt           <= '0;
            s             <= '0;
            r             <= '0;
            req.req_ready <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            q_shadow      <= '0;
            lat_data      <= '0;
            lat_mask      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_INIT: begin
                    // Bank state is unknown after power-up: reset every flop
                    // and treat the check as data=0, mask=all-ones.
                    state    <= ST_PULSE;
                    cnt      <= CW'(PULSE_CYCLES - 1);
                    s        <= '0;
                    r        <= '1;
                    lat_data <= '0;
                    lat_mask <= '1;
                end
                ST_IDLE: begin
                    if (accept) begin
                        lat_data <= req.req_data;
                        lat_mask <= req.req_mask;
                        if ((set_v | rst_v) == '0) begin
                            // Nothing to change: complete without touching the bank.
                            done <= 1'b1;
                        end else begin
                            state         <= ST_PULSE;
                            cnt           <= CW'(PULSE_CYCLES - 1);
                            s             <= set_v;
                            r             <= rst_v;
                            req.req_ready <= 1'b0;
                            busy          <= 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state <= ST_SETTLE;
                        cnt   <= CW'(SETTLE_CYCLES - 1);
                        s     <= '0;
                        r     <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_CHECK;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Shadow follows what the bank really holds, not the request.
                    state         <= ST_IDLE;
                    q_shadow      <= (q_shadow & ~lat_mask) | (q_fb & lat_mask);
                    req.req_ready <= 1'b1;
                    busy          <= 1'b0;
                end
                default: begin
                    state <= ST_INIT;
                    s     <= '0;
                    r     <= '0;
                end
            endcase
        end
    end

    // Sticky error capture; a mismatch in the same cycle as err_clr survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= 1'b0;
            err_bits <= '0;
        end else if (err_clr) begin
            err      <= |mism;
            err_bits <= mism;
        end else begin
            err      <= err | (|mism);
            err_bits <= err_bits | mism;
        end
    end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed bench for sr_bank_driver paired with an 8-bit SR flop bank model.
module tb_sr_bank_driver;
    import sr_bank_driver_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] s, r, q_fb, q_shadow, err_bits;
    logic       busy, done, err, err_clr;
    sr_state_t  state_dbg;
    logic [7:0] bank_q;
    logic [7:0] stuck0;
    int         n_checks;
    int         n_fail;

    sr_bank_driver_if #(.N(8)) ifc ();

    sr_bank_driver #(.N(8), .PULSE_CYCLES(2), .SETTLE_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (ifc.slave),
        .s         (s),
        .r         (r),
        .q_fb      (q_fb),
        .q_shadow  (q_shadow),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_bits  (err_bits),
        .err_clr   (err_clr),
        .state_dbg (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SR flop bank model (no reset); stuck0 forces selected q outputs low.
    initial bank_q = 8'h3C;
    always @(posedge clk) bank_q <= (bank_q | s) & ~r;
    assign q_fb = bank_q & ~stuck0;

    // s and r must never be active on the same bit.
    always @(negedge clk) begin
        n_checks++;
        if ((s & r) !== 8'h00) begin
            n_fail++;
            $display("FAIL sr_overlap: s=%h r=%h", s, r);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [7:0] d, input logic [7:0] m);
        ifc.req_valid = 1'b1;
        ifc.req_data  = d;
        ifc.req_mask  = m;
        step();
        ifc.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_checks += 9;
        if (s !== 8'h00)          begin n_fail++; $display("FAIL rst_s: got %h exp 00", s); end
        if (r !== 8'h00)          begin n_fail++; $display("FAIL rst_r: got %h exp 00", r); end
        if (ifc.req_ready !== 0)  begin n_fail++; $display("FAIL rst_ready: got %b exp 0", ifc.req_ready); end
        if (busy !== 1'b1)        begin n_fail++; $display("FAIL rst_busy: got %b exp 1", busy); end
        if (done !== 1'b0)        begin n_fail++; $display("FAIL rst_done: got %b exp 0", done); end
        if (err !== 1'b0)         begin n_fail++; $display("FAIL rst_err: got %b exp 0", err); end
        if (err_bits !== 8'h00)   begin n_fail++; $display("FAIL rst_err_bits: got %h exp 00", err_bits); end
        if (q_shadow !== 8'h00)   begin n_fail++; $display("FAIL rst_shadow: got %h exp 00", q_shadow); end
        if (state_dbg !== ST_INIT) begin n_fail++; $display("FAIL rst_state: got %0d exp %0d", state_dbg, ST_INIT); end
        rst = 1'b0;
    endtask

    // Called right after reset release.
    task automatic test_init_replay();
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks += 3;
            if (r !== 8'hFF) begin n_fail++; $display("FAIL init_r c%0d: got %h exp ff", i, r); end
            if (s !== 8'h00) begin n_fail++; $display("FAIL init_s c%0d: got %h exp 00", i, s); end
            if (done !== 0)  begin n_fail++; $display("FAIL init_done_early c%0d: got %b exp 0", i, done); end
        end
        step();
        n_checks += 2;
        if (r !== 8'h00) begin n_fail++; $display("FAIL init_settle_r: got %h exp 00", r); end
        if (done !== 0)  begin n_fail++; $display("FAIL init_settle_done: got %b exp 0", done); end
        step();
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b exp 1", done); end
        step();
        n_checks += 5;
        if (done !== 1'b0)        begin n_fail++; $display("FAIL init_done_drop: got %b exp 0", done); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL init_busy: got %b exp 0", busy); end
        if (ifc.req_ready !== 1)  begin n_fail++; $display("FAIL init_ready: got %b exp 1", ifc.req_ready); end
        if (q_shadow !== 8'h00)   begin n_fail++; $display("FAIL init_shadow: got %h exp 00", q_shadow); end
        if (err !== 1'b0)         begin n_fail++; $display("FAIL init_err: got %b exp 0", err); end
    endtask

    task automatic test_full_update();
        drive_req(8'hA5, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            n_checks += 3;
            if (s !== 8'hA5)       begin n_fail++; $display("FAIL full_s c%0d: got %h exp a5", i, s); end
            if (r !== 8'h00)       begin n_fail++; $display("FAIL full_r c%0d: got %h exp 00", i, r); end
            if (ifc.req_ready !== 0) begin n_fail++; $display("FAIL full_ready c%0d: got %b exp 0", i, ifc.req_ready); end
            step();
        end
        n_checks += 2;
        if (s !== 8'h00) begin n_fail++; $display("FAIL full_settle_s: got %h exp 00", s); end
        if (done !== 0)  begin n_fail++; $display("FAIL full_settle_done: got %b exp 0", done); end
        step();
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b exp 1", done); end
        step();
        n_checks += 2;
        if (q_shadow !== 8'hA5) begin n_fail++; $display("FAIL full_shadow: got %h exp a5", q_shadow); end
        if (ifc.req_ready !== 1) begin n_fail++; $display("FAIL full_ready_end: got %b exp 1", ifc.req_ready); end
    endtask

    task automatic test_masked_reset();
        drive_req(8'h0F, 8'hF0);
        for (int i = 0; i < 2; i++) begin
            n_checks += 2;
            if (s !== 8'h00) begin n_fail++; $display("FAIL mask_s c%0d: got %h exp 00", i, s); end
            if (r !== 8'hA0) begin n_fail++; $display("FAIL mask_r c%0d: got %h exp a0", i, r); end
            step();
        end
        step();
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL mask_done: got %b exp 1", done); end
        step();
        n_checks++;
        if (q_shadow !== 8'h05) begin n_fail++; $display("FAIL mask_shadow: got %h exp 05", q_shadow); end
    endtask

    task automatic test_noop();
        drive_req(8'h05, 8'h0F);
        n_checks += 5;
        if (done !== 1'b1)        begin n_fail++; $display("FAIL noop_done: got %b exp 1", done); end
        if (ifc.req_ready !== 1)  begin n_fail++; $display("FAIL noop_ready: got %b exp 1", ifc.req_ready); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL noop_busy: got %b exp 0", busy); end
        if ((s | r) !== 8'h00)    begin n_fail++; $display("FAIL noop_sr: got %h exp 00", s | r); end
        if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL noop_state: got %0d exp %0d", state_dbg, ST_IDLE); end
        step();
        n_checks += 3;
        if (done !== 1'b0)      begin n_fail++; $display("FAIL noop_done_drop: got %b exp 0", done); end
        if ((s | r) !== 8'h00)  begin n_fail++; $display("FAIL noop_sr2: got %h exp 00", s | r); end
        if (q_shadow !== 8'h05) begin n_fail++; $display("FAIL noop_shadow: got %h exp 05", q_shadow); end
    endtask

    task automatic test_stuck_error();
        stuck0 = 8'h08;
        drive_req(8'h08, 8'h08);
        n_checks++;
        if (s !== 8'h08) begin n_fail++; $display("FAIL stuck_s: got %h exp 08", s); end
        repeat (4) step();
        n_checks += 3;
        if (err !== 1'b1)       begin n_fail++; $display("FAIL stuck_err: got %b exp 1", err); end
        if (err_bits !== 8'h08) begin n_fail++; $display("FAIL stuck_err_bits: got %h exp 08", err_bits); end
        if (q_shadow !== 8'h05) begin n_fail++; $display("FAIL stuck_shadow: got %h exp 05", q_shadow); end
        // Plain clear while idle
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks += 2;
        if (err !== 1'b0)       begin n_fail++; $display("FAIL clr_err: got %b exp 0", err); end
        if (err_bits !== 8'h00) begin n_fail++; $display("FAIL clr_err_bits: got %h exp 00", err_bits); end
        // Clear coinciding with a fresh mismatch in CHECK
        drive_req(8'h08, 8'h08);
        repeat (3) step();
        n_checks++;
        if (state_dbg !== ST_CHECK) begin n_fail++; $display("FAIL clr_hit_state: got %0d exp %0d", state_dbg, ST_CHECK); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks += 2;
        if (err !== 1'b1)       begin n_fail++; $display("FAIL clr_vs_mism_err: got %b exp 1", err); end
        if (err_bits !== 8'h08) begin n_fail++; $display("FAIL clr_vs_mism_bits: got %h exp 08", err_bits); end
        // Bank healthy again: clean update, error stays sticky
        stuck0 = 8'h00;
        drive_req(8'h08, 8'h08);
        repeat (4) step();
        n_checks += 3;
        if (q_shadow !== 8'h0D) begin n_fail++; $display("FAIL sticky_shadow: got %h exp 0d", q_shadow); end
        if (err !== 1'b1)       begin n_fail++; $display("FAIL sticky_err: got %b exp 1", err); end
        if (err_bits !== 8'h08) begin n_fail++; $display("FAIL sticky_bits: got %h exp 08", err_bits); end
    endtask

    task automatic test_back_to_back();
        ifc.req_valid = 1'b1;
        ifc.req_data  = 8'hF0;
        ifc.req_mask  = 8'hF0;
        step();
        // Second request presented while busy; must not disturb the first.
        ifc.req_data = 8'h00;
        ifc.req_mask = 8'h0F;
        n_checks += 2;
        if (s !== 8'hF0) begin n_fail++; $display("FAIL b2b_s1: got %h exp f0", s); end
        if (r !== 8'h00) begin n_fail++; $display("FAIL b2b_r1: got %h exp 00", r); end
        repeat (3) step();
        n_checks++;
        if (ifc.req_ready !== 0) begin n_fail++; $display("FAIL b2b_busy_ready: got %b exp 0", ifc.req_ready); end
        step();
        n_checks += 2;
        if (ifc.req_ready !== 1) begin n_fail++; $display("FAIL b2b_ready: got %b exp 1", ifc.req_ready); end
        if (q_shadow !== 8'hFD)  begin n_fail++; $display("FAIL b2b_shadow1: got %h exp fd", q_shadow); end
        step();
        ifc.req_valid = 1'b0;
        n_checks += 2;
        if (s !== 8'h00) begin n_fail++; $display("FAIL b2b_s2: got %h exp 00", s); end
        if (r !== 8'h0D) begin n_fail++; $display("FAIL b2b_r2: got %h exp 0d", r); end
        repeat (4) step();
        n_checks++;
        if (q_shadow !== 8'hF0) begin n_fail++; $display("FAIL b2b_shadow2: got %h exp f0", q_shadow); end
    endtask

    task automatic test_reset_midop();
        drive_req(8'h00, 8'hFF);
        step();
        n_checks++;
        if (r !== 8'hF0) begin n_fail++; $display("FAIL mid_r_before: got %h exp f0", r); end
        rst = 1'b1;
        #1;
        n_checks += 4;
        if ((s | r) !== 8'h00)     begin n_fail++; $display("FAIL mid_sr_drop: got %h exp 00", s | r); end
        if (state_dbg !== ST_INIT) begin n_fail++; $display("FAIL mid_state: got %0d exp %0d", state_dbg, ST_INIT); end
        if (busy !== 1'b1)         begin n_fail++; $display("FAIL mid_busy: got %b exp 1", busy); end
        if (q_shadow !== 8'h00)    begin n_fail++; $display("FAIL mid_shadow: got %h exp 00", q_shadow); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done c%0d: got %b exp 0", i, done); end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        err_clr       = 1'b0;
        stuck0        = 8'h00;
        ifc.req_valid = 1'b0;
        ifc.req_data  = 8'h00;
        ifc.req_mask  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_init_replay();
        test_full_update();
        test_masked_reset();
        test_noop();
        test_stuck_error();
        test_back_to_back();
        test_reset_midop();
        test_init_replay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
